// File: rtl/dma_bus_master_if.sv
// Shared-bus connection between the DMA engine and the CPU/DMA bus mux.
// Ports (master view):
//   busrq_n    out  bus request to CPU, active-low
//   busak_n    in   bus acknowledge from CPU, active-low
//   dma_a      out  16-bit bus address
//   dma_din    in   8-bit read data
//   dma_dout   out  8-bit write data
//   dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n  out  bus strobes, active-low
interface dma_bus_master_if;
  logic        busrq_n;
  logic        busak_n;
  logic [15:0] dma_a;
  logic [7:0]  dma_din;
  logic [7:0]  dma_dout;
  logic        dma_mreq_n;
  logic        dma_iorq_n;
  logic        dma_rd_n;
  logic        dma_wr_n;

  modport master (
    output busrq_n, dma_a, dma_dout, dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n,
    input  busak_n, dma_din
  );

  modport slave (
    input  busrq_n, dma_a, dma_dout, dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n,
    output busak_n, dma_din
  );
endinterface

// File: rtl/dma_bus_master.sv
// Bus-mastering DMA engine: requests the Z80 bus via BUSRQ/BUSAK, then runs
// a burst of read-then-write byte transfers and releases the bus.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cen               CPU-rate clock enable; bus-side changes only on cen edges
//   start             one-clk launch pulse (ignored while busy)
//   src_addr/dst_addr start addresses, len byte count (0 = nothing to do)
//   src_io/dst_io     1 = IO space, 0 = memory
//   src_inc/dst_inc   1 = advance address per byte
//   abort             level, honoured at the next byte boundary
//   busy, done        status; done pulses one clk per accepted start
//   bus               shared-bus master modport
//
// state | meaning
// IDLE  | bus untouched; waits for start (or finishes a len=0 start)
// REQ   | busrq_n low, waiting for busak_n
// RD1   | source address on the bus
// RD2   | read strobes asserted
// RD3   | read strobes held; data captured on exit
// WR1   | destination address and write data on the bus
// WR2   | write strobes asserted
// WR3   | write strobes held; byte accounted on exit
// REL   | busrq_n high, waiting for busak_n to return high
module dma_bus_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        start,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [15:0] len,
  input  logic        src_io,
  input  logic        dst_io,
  input  logic        src_inc,
  input  logic        dst_inc,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  dma_bus_master_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, REQ, RD1, RD2, RD3, WR1, WR2, WR3, REL
  } state_t;

  state_t      state, state_nx;
  logic [15:0] src, src_nx, dst, dst_nx, cnt, cnt_nx;
  logic        sio, sio_nx, dio, dio_nx, sinc, sinc_nx, dinc, dinc_nx;
  logic        busy_q, busy_nx, done_q, done_nx;
  logic        zero_pend, zero_nx;
  logic        busrq_q, busrq_nx;
  logic [15:0] a_q, a_nx;
  logic [7:0]  dout_q, dout_nx;
  logic        mreq_q, mreq_nx, iorq_q, iorq_nx, rd_q, rd_nx, wr_q, wr_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      cnt       <= '0;
      sio       <= 1'b0;
      dio       <= 1'b0;
      sinc      <= 1'b0;
      dinc      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_pend <= 1'b0;
      busrq_q   <= 1'b1;
      a_q       <= '0;
      dout_q    <= '0;
      mreq_q    <= 1'b1;
      iorq_q    <= 1'b1;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
    end else begin
      state     <= state_nx;
      src       <= src_nx;
      dst       <= dst_nx;
      cnt       <= cnt_nx;
      sio       <= sio_nx;
      dio       <= dio_nx;
      sinc      <= sinc_nx;
      dinc      <= dinc_nx;
      busy_q    <= busy_nx;
      done_q    <= done_nx;
      zero_pend <= zero_nx;
      busrq_q   <= busrq_nx;
      a_q       <= a_nx;
      dout_q    <= dout_nx;
      mreq_q    <= mreq_nx;
      iorq_q    <= iorq_nx;
      rd_q      <= rd_nx;
      wr_q      <= wr_nx;
    end
  end

  // Every output is computed one step ahead here and registered above, so
  // the bus sees clean registered levels that move only on cen edges.
  always_comb begin
    state_nx = state;
    src_nx   = src;
    dst_nx   = dst;
    cnt_nx   = cnt;
    sio_nx   = sio;
    dio_nx   = dio;
    sinc_nx  = sinc;
    dinc_nx  = dinc;
    busy_nx  = busy_q;
    done_nx  = 1'b0;
    zero_nx  = zero_pend;
    busrq_nx = busrq_q;
    a_nx     = a_q;
    dout_nx  = dout_q;
    mreq_nx  = mreq_q;
    iorq_nx  = iorq_q;
    rd_nx    = rd_q;
    wr_nx    = wr_q;

    case (state)
      IDLE: begin
        if (zero_pend) begin
          // len=0: finish on the clk right after start, no bus activity
          done_nx = 1'b1;
          busy_nx = 1'b0;
          zero_nx = 1'b0;
        end else if (busy_q) begin
          // accepted start waits here for the first cen edge
          if (cen) begin
            state_nx = REQ;
            busrq_nx = 1'b0;
          end
        end else if (start) begin
          src_nx  = src_addr;
          dst_nx  = dst_addr;
          cnt_nx  = len;
          sio_nx  = src_io;
          dio_nx  = dst_io;
          sinc_nx = src_inc;
          dinc_nx = dst_inc;
          busy_nx = 1'b1;
          zero_nx = (len == 16'd0);
        end
      end
      REQ: begin
        if (cen && !bus.busak_n) begin
          state_nx = RD1;
          a_nx     = src;
        end
      end
      RD1: begin
        if (cen) begin
          state_nx = RD2;
          rd_nx    = 1'b0;
          mreq_nx  = sio;
          iorq_nx  = !sio;
        end
      end
      RD2: begin
        if (cen) state_nx = RD3;
      end
      RD3: begin
        if (cen) begin
          state_nx = WR1;
          dout_nx  = bus.dma_din;
          rd_nx    = 1'b1;
          mreq_nx  = 1'b1;
          iorq_nx  = 1'b1;
          a_nx     = dst;
        end
      end
      WR1: begin
        if (cen) begin
          state_nx = WR2;
          wr_nx    = 1'b0;
          mreq_nx  = dio;
          iorq_nx  = !dio;
        end
      end
      WR2: begin
        if (cen) state_nx = WR3;
      end
      WR3: begin
        if (cen) begin
          wr_nx   = 1'b1;
          mreq_nx = 1'b1;
          iorq_nx = 1'b1;
          cnt_nx  = cnt - 16'd1;
          src_nx  = src + {15'd0, sinc};
          dst_nx  = dst + {15'd0, dinc};
          if (cnt == 16'd1 || abort) begin
            state_nx = REL;
            busrq_nx = 1'b1;
          end else begin
            state_nx = RD1;
            a_nx     = src_nx;
          end
        end
      end
      REL: begin
        if (cen && bus.busak_n) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          a_nx     = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign bus.busrq_n    = busrq_q;
  assign bus.dma_a      = a_q;
  assign bus.dma_dout   = dout_q;
  assign bus.dma_mreq_n = mreq_q;
  assign bus.dma_iorq_n = iorq_q;
  assign bus.dma_rd_n   = rd_q;
  assign bus.dma_wr_n   = wr_q;

endmodule
